// File: rtl/game_stats_tracker.sv
// Game statistics for the end-game screen: centisecond stopwatch, pair counter
// and the win/timeout decision, all in the pixel clock domain.
module game_stats_tracker #(
    parameter int CLK_FREQ_HZ = 65_000_000,
    parameter int PAIRS_TOTAL = 8,
    parameter int MAX_SECONDS = 63
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        start,
    input  logic        pair_found,
    output logic [12:0] game_time,
    output logic [7:0]  discovered_pairs_ctr,
    output logic        game_over_en,
    output logic        game_won,
    output logic        running
);
    localparam int TICK_DIV = CLK_FREQ_HZ / 100;
    localparam int PW       = $clog2(TICK_DIV);

    localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [7:0]    PAIRS_LAST = 8'(PAIRS_TOTAL - 1);
    localparam logic [5:0]    SEC_MAX    = 6'(MAX_SECONDS);
    localparam logic [6:0]    HUND_MAX   = 7'd99;

    if (TICK_DIV < 2) begin : g_bad_div
        $error("game_stats_tracker: CLK_FREQ_HZ/100 must be at least 2");
    end
    if (PAIRS_TOTAL < 1 || PAIRS_TOTAL > 99) begin : g_bad_pairs
        $error("game_stats_tracker: PAIRS_TOTAL out of 1..99");
    end
    if (MAX_SECONDS < 0 || MAX_SECONDS > 63) begin : g_bad_secs
        $error("game_stats_tracker: MAX_SECONDS out of 0..63");
    end

    typedef enum logic [1:0] {IDLE, RUNNING, OVER} state_t;

    state_t        state;
    logic [PW-1:0] prescaler;
    logic [5:0]    seconds;
    logic [6:0]    hundredths;

    logic tick, at_limit, last_pair;

    assign tick      = (prescaler == PRE_LAST);
    assign at_limit  = (seconds == SEC_MAX) && (hundredths == HUND_MAX);
    assign last_pair = pair_found && (discovered_pairs_ctr == PAIRS_LAST);
    assign game_time = {seconds, hundredths};

    always_ff @(posedge pclk) begin
        if (rst) begin
            state                <= IDLE;
            prescaler            <= '0;
            seconds              <= '0;
            hundredths           <= '0;
            discovered_pairs_ctr <= '0;
            game_over_en         <= 1'b0;
            game_won             <= 1'b0;
            running              <= 1'b0;
        end else begin
            case (state)
                IDLE, OVER: begin
                    if (start) begin
                        state                <= RUNNING;
                        prescaler            <= '0;
                        seconds              <= '0;
                        hundredths           <= '0;
                        discovered_pairs_ctr <= '0;
                        game_over_en         <= 1'b0;
                        game_won             <= 1'b0;
                        running              <= 1'b1;
                    end
                end
                RUNNING: begin
                    // The final pair wins outright; a coincident tick (even the timeout one) is dropped.
                    if (last_pair) begin
                        state                <= OVER;
                        discovered_pairs_ctr <= discovered_pairs_ctr + 8'd1;
                        game_over_en         <= 1'b1;
                        game_won             <= 1'b1;
                        running              <= 1'b0;
                    end else begin
                        if (pair_found)
                            discovered_pairs_ctr <= discovered_pairs_ctr + 8'd1;
                        if (tick) begin
                            prescaler <= '0;
                            if (at_limit) begin
                                state        <= OVER;
                                game_over_en <= 1'b1;
                                running      <= 1'b0;
                            end else if (hundredths == HUND_MAX) begin
                                hundredths <= '0;
                                seconds    <= seconds + 6'd1;
                            end else begin
                                hundredths <= hundredths + 7'd1;
                            end
                        end else begin
                            prescaler <= prescaler + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_game_stats_tracker.sv
// Directed plan scenarios plus random start/pair/reset traffic, every cycle
// compared against a game model kept in elapsed-cycle / total-hundredths terms.
module tb_game_stats_tracker;
    localparam int CLK_HZ   = 1000;
    localparam int TDIV     = CLK_HZ / 100;
    localparam int PAIRS    = 3;
    localparam int MAX_S    = 1;
    localparam int LIMIT_T  = MAX_S * 100 + 99;

    logic        pclk = 1'b0;
    logic        rst = 1'b1, start = 1'b0, pair_found = 1'b0;
    logic [12:0] game_time;
    logic [7:0]  discovered_pairs_ctr;
    logic        game_over_en, game_won, running;

    game_stats_tracker #(
        .CLK_FREQ_HZ(CLK_HZ), .PAIRS_TOTAL(PAIRS), .MAX_SECONDS(MAX_S)
    ) dut (
        .pclk(pclk), .rst(rst), .start(start), .pair_found(pair_found),
        .game_time(game_time), .discovered_pairs_ctr(discovered_pairs_ctr),
        .game_over_en(game_over_en), .game_won(game_won), .running(running)
    );

    always #5 pclk = ~pclk;

    int n_chk = 0, n_pass = 0;

    // Model: game in progress, elapsed cycles since start, total hundredths.
    bit m_run, m_over, m_won;
    int m_cyc, m_t, m_pairs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [12:0] enc_time(input int t);
        logic [5:0] s;
        logic [6:0] h;
        s = 6'(t / 100);
        h = 7'(t % 100);
        return {s, h};
    endfunction

    task automatic model(input bit s, input bit p, input bit r);
        bit tick;
        if (r) begin
            m_run = 0; m_over = 0; m_won = 0; m_cyc = 0; m_t = 0; m_pairs = 0;
        end else if (!m_run) begin
            if (s) begin
                m_run = 1; m_over = 0; m_won = 0; m_cyc = 0; m_t = 0; m_pairs = 0;
            end
        end else begin
            m_cyc++;
            tick = (m_cyc % TDIV) == 0;
            if (p && m_pairs == PAIRS - 1) begin
                m_pairs++; m_run = 0; m_over = 1; m_won = 1;
            end else begin
                if (p) m_pairs++;
                if (tick) begin
                    if (m_t == LIMIT_T) begin m_run = 0; m_over = 1; end
                    else m_t++;
                end
            end
        end
    endtask

    // One clock: drive, advance model at the edge, compare 1 time unit later.
    task automatic step(input bit s, input bit p, input bit r);
        start = s; pair_found = p; rst = r;
        @(posedge pclk);
        model(s, p, r);
        #1;
        chk("time",    32'(game_time),            32'(enc_time(m_t)));
        chk("pairs",   32'(discovered_pairs_ctr), 32'(m_pairs));
        chk("over",    32'(game_over_en),         32'(m_over));
        chk("won",     32'(game_won),             32'(m_won));
        chk("running", 32'(running),              32'(m_run));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    initial begin
        // Reset state
        step(0, 0, 1);
        chk("rst_time", 32'(game_time), 32'h0);
        chk("rst_run",  32'(running), 32'h0);
        idle(5);
        chk("idle_hold", 32'(game_time), 32'h0);

        // 1: first tick 10 cycles after entry, 1.00 after 1000
        step(1, 0, 0);
        chk("t1_running", 32'(running), 32'h1);
        idle(9);
        chk("t1_pre_tick", 32'(game_time), 32'h000);
        idle(1);
        chk("t1_first_tick", 32'(game_time), 32'h001);
        idle(990);
        chk("t1_one_sec", 32'(game_time), 32'h080);

        // 2: three pairs -> win, time frozen
        step(0, 0, 1);
        step(1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0);
            chk("t2_pairs", 32'(discovered_pairs_ctr), 32'(k + 1));
            if (k < 2) idle(4);
        end
        chk("t2_over", 32'(game_over_en), 32'h1);
        chk("t2_won",  32'(game_won), 32'h1);
        chk("t2_run",  32'(running), 32'h0);
        idle(50);
        chk("t2_frozen", 32'(game_time), 32'h001);

        // 3: timeout at 1.99, no wrap
        step(1, 0, 0);
        idle(1990);
        chk("t3_limit", 32'(game_time), 32'h0E3);
        chk("t3_still_run", 32'(running), 32'h1);
        idle(10);
        chk("t3_over", 32'(game_over_en), 32'h1);
        chk("t3_lost", 32'(game_won), 32'h0);
        idle(30);
        chk("t3_no_wrap", 32'(game_time), 32'h0E3);

        // 4: final pair on the timeout tick -> win, time not advanced
        step(1, 0, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        idle(1997);
        step(0, 1, 0);
        chk("t4_won",   32'(game_won), 32'h1);
        chk("t4_time",  32'(game_time), 32'h0E3);
        chk("t4_pairs", 32'(discovered_pairs_ctr), 32'h3);

        // 5: OVER ignores pairs, start restarts; mid-game start ignored
        step(0, 1, 0);
        chk("t5_pair_ign", 32'(discovered_pairs_ctr), 32'h3);
        step(1, 0, 0);
        chk("t5_restart_run",  32'(running), 32'h1);
        chk("t5_restart_over", 32'(game_over_en), 32'h0);
        chk("t5_restart_won",  32'(game_won), 32'h0);
        chk("t5_restart_time", 32'(game_time), 32'h0);
        chk("t5_restart_prs",  32'(discovered_pairs_ctr), 32'h0);
        step(1, 0, 0);
        idle(19);
        chk("t5_start_ign", 32'(game_time), 32'h002);

        // 6: reset mid-game with pair_found high
        step(0, 0, 1);
        step(1, 0, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        idle(568);
        chk("t6_time", 32'(game_time), 32'd57);
        step(0, 1, 1);
        chk("t6_rst_time",  32'(game_time), 32'h0);
        chk("t6_rst_pairs", 32'(discovered_pairs_ctr), 32'h0);
        chk("t6_rst_run",   32'(running), 32'h0);
        idle(30);
        chk("t6_idle_time", 32'(game_time), 32'h0);

        // Random traffic
        for (int i = 0; i < 20000; i++)
            step($urandom_range(199) == 0, $urandom_range(29) == 0, $urandom_range(1999) == 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
